// File: rtl/rr_grant_fsm_pkg.sv
// Shared definitions for the round-robin grant FSM: state encodings and default sizing.
`default_nettype none

package rr_grant_fsm_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_grant_fsm_pick.sv
// Combinational rotating-priority picker: nearest request after `last`, wrapping, `last` itself lowest.
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int p;

  // Walk from the farthest candidate to the nearest so the nearest hit overwrites the others.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = N; k >= 1; k--) begin
      p = (int'(last) + k) % N;
      if (req[p]) begin
        valid = 1'b1;
        idx   = IW'(p);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter with bounded tenure and a single dead cycle between owners; Moore outputs.
`default_nettype none

module rr_grant_fsm
  import rr_grant_fsm_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  state_t        state;
  logic [IW-1:0] last;
  logic [CW-1:0] hold_cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      last     <= IW'(N - 1);
    end else begin
      case (state)
        // RELEASE already carries the updated `last`, so it arbitrates exactly like IDLE.
        ST_IDLE, ST_RELEASE: begin
          if (pick_valid) begin
            state    <= ST_GRANT;
            gnt      <= N'(1) << pick_idx;
            gnt_id   <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= CW'(1);
          end else begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!req[gnt_id] || hold_cnt == CW'(MAX_HOLD)) begin
            state <= ST_RELEASE;
            gnt   <= '0;
            last  <= gnt_id;
            busy  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          gnt      <= '0;
          gnt_id   <= '0;
          busy     <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_fsm.sv
// Scoreboard bench for rr_grant_fsm (N=4, MAX_HOLD=8) using hand-derived grant sequences.
`default_nettype none

module tb_rr_grant_fsm;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  exp_t q[$];
  int   applied     = 0;
  int   miscompares = 0;

  rr_grant_fsm #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and queue the outputs expected after the next rising edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] eid, input logic eb, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.gnt  = eg;
    e.id   = eid;
    e.busy = eb;
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: one registered output set per clock, checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        applied++;
        if (gnt !== e.gnt || gnt_id !== e.id || busy !== e.busy) begin
          miscompares++;
          $display("FAIL %s: got gnt=%b gnt_id=%0d busy=%b, expected gnt=%b gnt_id=%0d busy=%b",
                   e.name, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no summary, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] o;
    int         drain;

    // Reset held with every request asserted, then requester 0 wins first.
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset_0");
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset_1");

    // Full contention: owners 0,1,2,3,0 for 8 cycles each, one dead cycle between.
    for (int r = 0; r < 5; r++) begin
      o = 2'(r % 4);
      for (int c = 0; c < 8; c++)
        step(1'b0, 4'b1111, 4'b0001 << o, o, 1'b1, "contend_gnt");
      step(1'b0, 4'b1111, 4'b0000, o, 1'b1, "contend_dead");
    end
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_idle");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_hold");

    // Sole requester 2 repeatedly re-wins after each forced release.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++)
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "single_gnt");
      step(1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1, "single_dead");
    end
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_idle");

    // Early release: req0 for 3 cycles alongside req2.
    for (int c = 0; c < 3; c++)
      step(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, "early_gnt0");
    step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b1, "early_dead");
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "early_gnt2");

    // Owner 2 reaches hold_cnt 4, then reset restarts priority at requester 0.
    for (int c = 0; c < 3; c++)
      step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "pre_rst_gnt2");
    step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, "mid_rst");
    step(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, "post_rst_gnt2");
    step(1'b0, 4'b1000, 4'b0000, 2'd2, 1'b1, "post_rst_dead");
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, "gnt3");

    // Owner 3 drops its request in the same cycle its tenure expires.
    for (int c = 0; c < 7; c++)
      step(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, "limit_gnt3");
    step(1'b0, 4'b0001, 4'b0000, 2'd3, 1'b1, "limit_drop_dead");
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "limit_next_gnt0");
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "limit_hold_gnt0");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, "final_dead");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "final_idle");

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
